// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first.
// Ports: Clk, Rst_n, Start, A, B in; Busy, Done, Diff, Borrow out.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             load;
  logic             last;
  logic             d;
  logic             br_n;

  assign last = (cnt_q == CW'(WIDTH - 1));
  assign d    = a_q[0] ^ b_q[0] ^ br_q;
  assign br_n = (~a_q[0] & b_q[0])
              | (~(a_q[0] ^ b_q[0]) & br_q);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = SHIFT;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        if (Start) begin
          state_d = SHIFT;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_q <= state_d;
      Busy    <= (state_d == SHIFT);
      Done    <= (state_d == DONE);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      br_q   <= 1'b0;
      Diff   <= '0;
      Borrow <= 1'b0;
    end else if (load) begin
      a_q   <= A;
      b_q   <= B;
      res_q <= '0;
      cnt_q <= '0;
      br_q  <= 1'b0;
    end else if (state_q == SHIFT) begin
      a_q   <= {1'b0, a_q[WIDTH-1:1]};
      b_q   <= {1'b0, b_q[WIDTH-1:1]};
      res_q <= {d, res_q[WIDTH-1:1]};
      cnt_q <= cnt_q + 1'b1;
      br_q  <= br_n;
      // final bit goes straight to the output
      if (last) begin
        Diff   <= {d, res_q[WIDTH-1:1]};
        Borrow <= br_n;
      end
    end
  end

endmodule
